// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared widths, FSM state type and window packing helper
//
// Purpose : common definitions for the frame scheduler and its address generator.
// Contents: PIX_W / WIN_W / RES_W widths, TAPS (window size), conv_state_e,
//           win_lsb() giving the LSB of tap (i,j) inside the 72-bit window word.
package conv_pkg;

  localparam int PIX_W = 8;
  localparam int WIN_W = 72;
  localparam int RES_W = 24;
  localparam int TAPS  = 9;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CONV,
    WRITE,
    DONE
  } conv_state_e;

  // Row-major packing: top-left pixel in [7:0], bottom-right in [71:64].
  function automatic int win_lsb(input int i, input int j);
    return PIX_W * (3 * i + j);
  endfunction

endpackage

// File: rtl/window_addr_gen.sv
// rtl/window_addr_gen.sv - output-position and 3x3 tap counters with RAM addresses
//
// Purpose : tracks the current output (row,col) and the read tap (i,j) of its window.
// Ports   : clk, reset (async, active-low)
//           frame_clr  - restart the frame at output (0,0)
//           tap_en     - a read is issued this cycle; step to the next tap
//           tap_clr    - rewind the tap counter (held outside FETCH)
//           advance    - current output written; move to the next output
//           rd_addr    - (row+i)*IMG_W + (col+j)
//           wr_addr    - row*(IMG_W-2) + col
//           tap_i/j    - current tap coordinates
//           taps_issued- all nine reads of the window have been issued
//           last       - current output is the final one of the frame
module window_addr_gen
  import conv_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_clr,
  input  logic              tap_en,
  input  logic              tap_clr,
  input  logic              advance,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [1:0]        tap_i,
  output logic [1:0]        tap_j,
  output logic              taps_issued,
  output logic              last
);

  localparam int OUT_W = IMG_W - 2;
  localparam int OUT_H = IMG_H - 2;
  localparam int RW    = $clog2(IMG_H);
  localparam int CW    = $clog2(IMG_W);

  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [3:0]    tap;

  assign last        = (row == RW'(OUT_H - 1)) && (col == CW'(OUT_W - 1));
  assign taps_issued = (tap == 4'(TAPS));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row <= '0;
      col <= '0;
    end else if (frame_clr) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (last) begin
        row <= '0;
        col <= '0;
      end else if (col == CW'(OUT_W - 1)) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tap   <= '0;
      tap_i <= '0;
      tap_j <= '0;
    end else if (tap_clr) begin
      tap   <= '0;
      tap_i <= '0;
      tap_j <= '0;
    end else if (tap_en) begin
      tap <= tap + 1'b1;
      if (tap_j == 2'd2) begin
        tap_j <= '0;
        tap_i <= tap_i + 1'b1;
      end else begin
        tap_j <= tap_j + 1'b1;
      end
    end
  end

  assign rd_addr = (ADDR_W'(row) + ADDR_W'(tap_i)) * ADDR_W'(IMG_W)
                 + ADDR_W'(col) + ADDR_W'(tap_j);
  assign wr_addr = ADDR_W'(row) * ADDR_W'(OUT_W) + ADDR_W'(col);

endmodule

// File: rtl/conv_frame_scheduler.sv
// rtl/conv_frame_scheduler.sv - sequences a 3x3 convolution unit over a whole image
//
// Purpose : fetches each 3x3 window in raster order, runs it through the external
//           convolution unit and stores each 24-bit result in the result RAM.
// Ports   : clk, reset (async, active-low)
//           go, kernel_in            - host start pulse and kernel (captured on go)
//           rd_en/rd_addr/rd_data    - pixel RAM, data one cycle after rd_en
//           conv_data/conv_kernel/conv_start/conv_done/conv_result - convolution unit
//           wr_en/wr_addr/wr_data    - result RAM write
//           busy, frame_done, error  - status (error is sticky until the next go)
module conv_frame_scheduler
  import conv_pkg::*;
#(
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 8,
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [WIN_W-1:0]  kernel_in,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic [WIN_W-1:0]  conv_data,
  output logic [WIN_W-1:0]  conv_kernel,
  output logic              conv_start,
  input  logic              conv_done,
  input  logic [RES_W-1:0]  conv_result,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [RES_W-1:0]  wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              error
);

  localparam int TW = $clog2(TIMEOUT + 1);

  conv_state_e   state;
  conv_state_e   state_nxt;
  logic [TW-1:0] conv_cnt;
  logic          taps_issued;
  logic          last_out;
  logic [1:0]    tap_i;
  logic [1:0]    tap_j;
  logic          cap_en;
  logic [6:0]    cap_lsb;
  logic          go_ok;
  logic          conv_timeout;

  assign go_ok = (state == IDLE) && go;
  // A done arriving on the final allowed cycle still wins over the abort.
  assign conv_timeout = (state == CONV) && !conv_done && (conv_cnt == TW'(TIMEOUT - 1));

  window_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W)
  ) u_addr (
    .clk        (clk),
    .reset      (reset),
    .frame_clr  (go_ok),
    .tap_en     (rd_en),
    .tap_clr    (state != FETCH),
    .advance    (wr_en),
    .rd_addr    (rd_addr),
    .wr_addr    (wr_addr),
    .tap_i      (tap_i),
    .tap_j      (tap_j),
    .taps_issued(taps_issued),
    .last       (last_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = FETCH;
      // Tap 9 is the cycle the last read's data is captured.
      FETCH:   if (taps_issued) state_nxt = CONV;
      CONV: begin
        if (conv_done)         state_nxt = WRITE;
        else if (conv_timeout) state_nxt = IDLE;
      end
      WRITE:   state_nxt = last_out ? DONE : FETCH;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_en      = 1'b0;
    conv_start = 1'b0;
    wr_en      = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      FETCH: begin
        busy  = 1'b1;
        rd_en = !taps_issued;
      end
      CONV: begin
        busy       = 1'b1;
        conv_start = 1'b1;
      end
      WRITE: begin
        busy  = 1'b1;
        wr_en = 1'b1;
      end
      DONE: begin
        busy       = 1'b1;
        frame_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Read data lags its address by one cycle, so the target byte lane is
  // remembered alongside a delayed read strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_en      <= 1'b0;
      cap_lsb     <= '0;
      conv_data   <= '0;
      conv_kernel <= '0;
      conv_cnt    <= '0;
      wr_data     <= '0;
      error       <= 1'b0;
    end else begin
      cap_en  <= rd_en;
      cap_lsb <= 7'(win_lsb(int'(tap_i), int'(tap_j)));
      if (cap_en) conv_data[cap_lsb +: PIX_W] <= rd_data;

      if (state == CONV) conv_cnt <= conv_cnt + 1'b1;
      else               conv_cnt <= '0;

      if (go_ok) begin
        conv_kernel <= kernel_in;
        error       <= 1'b0;
      end else if (conv_timeout) begin
        error <= 1'b1;
      end

      if ((state == CONV) && conv_done) wr_data <= conv_result;
    end
  end

endmodule
